// File: rtl/om_ctrl.sv
// om_ctrl: clears the output memory, then round-robins a write and a read requester
// onto its single RAM port.
// Ports:
//   iClk, iReset_n (sync, active low)
//   iStart/oBusy/oDone : clear control and status
//   iWr_*/oWr_ack      : write requester
//   iRd_*/oRd_*        : read requester and read-return data
//   o*_OM/iData_from_OM: OM RAM port
module om_ctrl #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4800,
  parameter logic [DATA_W-1:0] INIT_VALUE = 'h0011EB85,
  parameter int RD_LAT = 2
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iStart,
  output logic              oBusy,
  output logic              oDone,
  input  logic              iWr_req,
  input  logic [ADDR_W-1:0] iWr_addr,
  input  logic [DATA_W-1:0] iWr_data,
  output logic              oWr_ack,
  input  logic              iRd_req,
  input  logic [ADDR_W-1:0] iRd_addr,
  output logic              oRd_ack,
  output logic              oRd_valid,
  output logic [DATA_W-1:0] oRd_data,
  output logic [ADDR_W-1:0] oAddr_OM,
  output logic              oWrreq_OM,
  output logic              oRdreq_OM,
  output logic [DATA_W-1:0] oData_to_OM,
  input  logic [DATA_W-1:0] iData_from_OM
);

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

  typedef enum logic [1:0] {IDLE, CLEAR, SERVE} state_t;

  state_t            state;
  logic              lastRd;
  logic [RD_LAT-1:0] rdPipe;
  logic [RD_LAT-1:0] rngPipe;

  logic wrIn, rdIn, wrElig, rdElig;
  logic serveGo, startNow, grantWr, grantRd;

  always_comb begin
    wrIn     = {1'b0, iWr_addr} < DEPTH_X;
    rdIn     = {1'b0, iRd_addr} < DEPTH_X;
    // an ack showing this cycle belongs to the request still on the bus
    wrElig   = iWr_req && !oWr_ack;
    rdElig   = iRd_req && !oRd_ack;
    startNow = iStart && (state == IDLE || state == SERVE);
    serveGo  = (state == SERVE) && !iStart;
    grantWr  = serveGo && wrElig && (!rdElig || lastRd);
    grantRd  = serveGo && rdElig && !grantWr;
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state       <= IDLE;
      lastRd      <= 1'b1;
      rdPipe      <= '0;
      rngPipe     <= '0;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oWr_ack     <= 1'b0;
      oRd_ack     <= 1'b0;
      oRd_valid   <= 1'b0;
      oRd_data    <= '0;
      oAddr_OM    <= '0;
      oWrreq_OM   <= 1'b0;
      oRdreq_OM   <= 1'b0;
      oData_to_OM <= '0;
    end else begin
      oWrreq_OM <= 1'b0;
      oRdreq_OM <= 1'b0;
      oWr_ack   <= 1'b0;
      oRd_ack   <= 1'b0;
      oDone     <= 1'b0;

      // read-return pipe runs in every state so a clear
      // cannot swallow reads that were already acked
      for (int i = RD_LAT-1; i > 0; i--) begin
        rdPipe[i]  <= rdPipe[i-1];
        rngPipe[i] <= rngPipe[i-1];
      end
      rdPipe[0]  <= grantRd;
      rngPipe[0] <= rdIn;
      oRd_valid  <= rdPipe[RD_LAT-1];
      if (rdPipe[RD_LAT-1])
        oRd_data <= rngPipe[RD_LAT-1] ? iData_from_OM : '0;

      if (startNow) begin
        state       <= CLEAR;
        oBusy       <= 1'b1;
        oWrreq_OM   <= 1'b1;
        oAddr_OM    <= '0;
        oData_to_OM <= INIT_VALUE;
        oDone       <= (DEPTH == 1);
      end else begin
        unique case (state)
          IDLE: ;
          CLEAR: begin
            if (oAddr_OM == LAST) begin
              state <= SERVE;
              oBusy <= 1'b0;
            end else begin
              oWrreq_OM <= 1'b1;
              oAddr_OM  <= oAddr_OM + 1'b1;
              oDone     <= (oAddr_OM + 1'b1) == LAST;
            end
          end
          SERVE: begin
            if (grantWr) begin
              oWr_ack     <= 1'b1;
              oWrreq_OM   <= wrIn;
              oAddr_OM    <= iWr_addr;
              oData_to_OM <= iWr_data;
              lastRd      <= 1'b0;
            end else if (grantRd) begin
              oRd_ack   <= 1'b1;
              oRdreq_OM <= rdIn;
              oAddr_OM  <= iRd_addr;
              lastRd    <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_om_ctrl.sv
// tb_om_ctrl: directed and randomized bench for om_ctrl with a
// transaction-level reference model and a behavioural OM RAM.
module tb_om_ctrl;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int DEPTH = 4800;
  localparam int RD_LAT = 2;
  localparam logic [31:0] INIT = 32'h0011EB85;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          iReset_n, iStart, oBusy, oDone;
  logic          iWr_req, oWr_ack, iRd_req, oRd_ack, oRd_valid;
  logic [AW-1:0] iWr_addr, iRd_addr, oAddr_OM;
  logic [DW-1:0] iWr_data, oRd_data, oData_to_OM, iData_from_OM;
  logic          oWrreq_OM, oRdreq_OM;

  om_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
    .INIT_VALUE(INIT), .RD_LAT(RD_LAT)
  ) dut (
    .iClk(clk), .iReset_n(iReset_n), .iStart(iStart),
    .oBusy(oBusy), .oDone(oDone),
    .iWr_req(iWr_req), .iWr_addr(iWr_addr), .iWr_data(iWr_data),
    .oWr_ack(oWr_ack),
    .iRd_req(iRd_req), .iRd_addr(iRd_addr), .oRd_ack(oRd_ack),
    .oRd_valid(oRd_valid), .oRd_data(oRd_data),
    .oAddr_OM(oAddr_OM), .oWrreq_OM(oWrreq_OM), .oRdreq_OM(oRdreq_OM),
    .oData_to_OM(oData_to_OM), .iData_from_OM(iData_from_OM)
  );

  // OM RAM: read data appears the cycle after the strobe
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ramQ;
  assign iData_from_OM = ramQ;
  always @(posedge clk) begin
    if (oWrreq_OM && oAddr_OM < DEPTH) mem[oAddr_OM] <= oData_to_OM;
    if (oRdreq_OM && oAddr_OM < DEPTH) ramQ <= mem[oAddr_OM];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_CLEAR, M_SERVE} mode_t;
  typedef struct {int due; logic [31:0] d;} rd_t;

  rd_t         pend[$];
  logic [31:0] shadow [DEPTH];
  mode_t       mode = M_IDLE;
  int          clrIdx = 0;
  bit          lastRd = 1'b1;
  bit          modelOn = 1'b0;

  logic          eWrreq, eRdreq, eWrAck, eRdAck, eBusy, eDone, eValid;
  logic [AW-1:0] eAddr;
  logic [31:0]   eData, eRdData;

  always @(negedge clk) begin : model
    logic          nWrreq, nRdreq, nWrAck, nRdAck, nBusy, nDone, nValid;
    logic [AW-1:0] nAddr;
    logic [31:0]   nData;
    logic          wE, rE;
    int            doClr;
    if (modelOn) begin
      chk("wrreq", oWrreq_OM, eWrreq);
      chk("rdreq", oRdreq_OM, eRdreq);
      chk("wr_ack", oWr_ack, eWrAck);
      chk("rd_ack", oRd_ack, eRdAck);
      chk("busy", oBusy, eBusy);
      chk("done", oDone, eDone);
      chk("rd_valid", oRd_valid, eValid);
      if (eWrreq || eRdreq || eWrAck || eRdAck) chk("addr", oAddr_OM, eAddr);
      if (eWrreq) chk("wdata", oData_to_OM, eData);
      if (eValid) chk("rdata", oRd_data, eRdData);
    end
    if (!iReset_n) begin
      modelOn = 1'b1;
      mode = M_IDLE;
      lastRd = 1'b1;
      pend.delete();
      {eWrreq, eRdreq, eWrAck, eRdAck, eBusy, eDone, eValid} = '0;
      eAddr = '0; eData = '0; eRdData = '0;
    end else if (modelOn) begin
      {nWrreq, nRdreq, nWrAck, nRdAck, nBusy, nDone, nValid} = '0;
      nAddr = eAddr;
      nData = eData;
      doClr = -1;
      case (mode)
        M_IDLE: if (iStart) doClr = 0;
        M_CLEAR: begin
          if (clrIdx == DEPTH-1) mode = M_SERVE;
          else doClr = clrIdx + 1;
        end
        M_SERVE: begin
          if (iStart) doClr = 0;
          else begin
            wE = iWr_req && !eWrAck;
            rE = iRd_req && !eRdAck;
            if (wE && (!rE || lastRd)) begin
              nWrAck = 1'b1; nAddr = iWr_addr; nData = iWr_data;
              lastRd = 1'b0;
              if (iWr_addr < DEPTH) begin
                nWrreq = 1'b1;
                shadow[iWr_addr] = iWr_data;
              end
            end else if (rE) begin
              nRdAck = 1'b1; nAddr = iRd_addr;
              lastRd = 1'b1;
              nRdreq = iRd_addr < DEPTH;
              pend.push_back('{due: cyc + 1 + RD_LAT,
                               d: nRdreq ? shadow[iRd_addr] : 32'h0});
            end
          end
        end
        default: ;
      endcase
      if (doClr >= 0) begin
        mode = M_CLEAR; clrIdx = doClr;
        nWrreq = 1'b1; nAddr = doClr[AW-1:0]; nData = INIT;
        nBusy = 1'b1; nDone = (doClr == DEPTH-1);
        shadow[doClr] = INIT;
      end
      if (pend.size() > 0 && pend[0].due == cyc + 1) begin
        nValid = 1'b1;
        eRdData = pend[0].d;
        void'(pend.pop_front());
      end
      eWrreq = nWrreq; eRdreq = nRdreq; eWrAck = nWrAck; eRdAck = nRdAck;
      eBusy = nBusy; eDone = nDone; eValid = nValid;
      eAddr = nAddr; eData = nData;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic waitServe();
    for (int k = 0; k < 6000 && oBusy; k++) step();
    chk("clear_timeout", oBusy, 1'b0);
  endtask

  function automatic logic [AW-1:0] rndAddr();
    int r = $urandom_range(0, 7);
    if (r == 0) return AW'($urandom_range(DEPTH, 8191));
    if (r < 4) return AW'($urandom_range(0, 63));
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  task automatic chkZero(input string nm);
    chk({nm, "_flags"}, {oBusy, oDone, oWr_ack, oRd_ack, oRd_valid,
                         oWrreq_OM, oRdreq_OM}, 32'h0);
    chk({nm, "_addr"}, oAddr_OM, 32'h0);
    chk({nm, "_wdata"}, oData_to_OM, 32'h0);
    chk({nm, "_rdata"}, oRd_data, 32'h0);
  endtask

  initial begin
    int busyN, doneN, doneAt, seqBad, ackSeen, oneBad;
    logic [7:0] wSeq, rSeq;
    iReset_n = 1'b0; iStart = 1'b0;
    iWr_req = 1'b0; iWr_addr = '0; iWr_data = '0;
    iRd_req = 1'b0; iRd_addr = '0;
    repeat (3) step();
    chkZero("reset");

    // 1: full clear from IDLE
    iReset_n = 1'b1; iStart = 1'b1;
    step();
    iStart = 1'b0;
    busyN = 0; doneN = 0; doneAt = -1; seqBad = 0;
    for (int k = 0; k < 6000 && oBusy; k++) begin
      busyN++;
      if (!oWrreq_OM || oAddr_OM != AW'(busyN-1) || oData_to_OM != INIT)
        seqBad++;
      if (oDone) begin doneN++; doneAt = oAddr_OM; end
      step();
    end
    chk("clr_busy_cycles", busyN, 4800);
    chk("clr_sequence", seqBad, 0);
    chk("clr_done_count", doneN, 1);
    chk("clr_done_addr", doneAt, 4799);

    // 2: write then read back addr 100
    iWr_req = 1'b1; iWr_addr = 13'd100; iWr_data = 32'hDEADBEEF;
    step();
    chk("t2_wr_grant", {oWrreq_OM, oWr_ack, oAddr_OM}, {2'b11, 13'd100});
    iWr_req = 1'b0;
    iRd_req = 1'b1; iRd_addr = 13'd100;
    step();
    chk("t2_rd_grant", {oRdreq_OM, oRd_ack, oAddr_OM}, {2'b11, 13'd100});
    iRd_req = 1'b0;
    step();
    chk("t2_valid_early", oRd_valid, 1'b0);
    step();
    chk("t2_rd_valid", oRd_valid, 1'b1);
    chk("t2_rd_data", oRd_data, 32'hDEADBEEF);

    // 3: both held -> W,R,W,R...
    iWr_req = 1'b1; iWr_addr = 13'd200; iWr_data = $urandom;
    iRd_req = 1'b1; iRd_addr = 13'd300;
    wSeq = '0; rSeq = '0; oneBad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      wSeq[i] = oWr_ack;
      rSeq[i] = oRd_ack;
      if (int'(oWrreq_OM) + int'(oRdreq_OM) != 1) oneBad++;
      if (oWr_ack) begin iWr_addr = 13'(200 + i); iWr_data = $urandom; end
      if (oRd_ack) iRd_addr = 13'(300 + i);
    end
    chk("t3_write_seq", wSeq, 8'h55);
    chk("t3_read_seq", rSeq, 8'hAA);
    chk("t3_one_strobe", oneBad, 0);
    iWr_req = 1'b0; iRd_req = 1'b0;
    repeat (4) step();

    // 4: out-of-range accesses
    iRd_req = 1'b1; iRd_addr = 13'd4800;
    step();
    chk("t4_rd_oor", {oRd_ack, oRdreq_OM}, 2'b10);
    iRd_req = 1'b0;
    iWr_req = 1'b1; iWr_addr = 13'd5000; iWr_data = $urandom;
    step();
    chk("t4_wr_oor", {oWr_ack, oWrreq_OM}, 2'b10);
    iWr_req = 1'b0;
    step();
    chk("t4_rd_valid", oRd_valid, 1'b1);
    chk("t4_rd_data", oRd_data, 32'h0);
    step();

    // 5: requests ignored in CLEAR, reset aborts at 2000
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    iWr_req = 1'b1; iWr_addr = 13'd7; iWr_data = 32'h12345678;
    iRd_req = 1'b1; iRd_addr = 13'd9;
    ackSeen = 0;
    for (int k = 0; k < 6000 && !(oBusy && oAddr_OM == 13'd2000); k++) begin
      ackSeen += int'(oWr_ack | oRd_ack);
      step();
    end
    chk("t5_at_2000", {oBusy, oAddr_OM}, {1'b1, 13'd2000});
    chk("t5_no_ack_clear", ackSeen, 0);
    iReset_n = 1'b0;
    step();
    chkZero("t5_reset");
    iReset_n = 1'b1;
    ackSeen = 0;
    repeat (5) begin
      step();
      ackSeen += int'(oWr_ack | oRd_ack | oWrreq_OM | oRdreq_OM | oBusy);
    end
    chk("t5_idle_quiet", ackSeen, 0);
    iWr_req = 1'b0; iRd_req = 1'b0;

    // 6: clear from SERVE keeps an acked read alive
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    waitServe();
    iRd_req = 1'b1; iRd_addr = 13'd100;
    step();
    chk("t6_rd_ack", oRd_ack, 1'b1);
    iRd_req = 1'b0; iStart = 1'b1;
    step();
    iStart = 1'b0;
    chk("t6_clear_at_0", {oBusy, oWrreq_OM, oAddr_OM}, {2'b11, 13'd0});
    step();
    chk("t6_rd_valid", oRd_valid, 1'b1);
    chk("t6_rd_data", oRd_data, INIT);
    waitServe();

    // randomized traffic
    for (int n = 0; n < 15000; n++) begin
      if (!iWr_req || oWr_ack) begin
        iWr_req = $urandom_range(0, 2) != 0;
        iWr_addr = rndAddr();
        iWr_data = $urandom;
      end
      if (!iRd_req || oRd_ack) begin
        iRd_req = $urandom_range(0, 2) != 0;
        iRd_addr = rndAddr();
      end
      iStart = $urandom_range(0, 2999) == 0;
      if ($urandom_range(0, 7999) == 0) begin
        iReset_n = 1'b0;
        step();
        iReset_n = 1'b1;
        iStart = 1'b1;
      end
      step();
    end
    iWr_req = 1'b0; iRd_req = 1'b0; iStart = 1'b0;
    repeat (10) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
